// File: rtl/i2s_frame_sequencer.sv
// I2S master/capture sequencer: generates SCK/WS from the system clock and deserializes
// stereo frames of DATA_BITS-wide samples, with start/stop handshake and frame counting.
module i2s_frame_sequencer #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned DATA_BITS   = 24,
  parameter int unsigned DATA_OFFSET = 2,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [FRAME_CNT_W-1:0] frames_i,
  input  logic                   sd_i,
  output logic                   sck_o,
  output logic                   ws_o,
  output logic [DATA_BITS-1:0]   left_o,
  output logic [DATA_BITS-1:0]   right_o,
  output logic                   sample_valid_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  localparam logic [DivW-1:0] DivMax    = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitMax    = BitW'(SLOT_BITS - 1);
  localparam logic [BitW-1:0] DataFirst = BitW'(DATA_OFFSET);
  localparam logic [BitW-1:0] DataLast  = BitW'(DATA_OFFSET + DATA_BITS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic                   sck_q, sck_d;
  logic                   ws_q, ws_d;
  logic [FRAME_CNT_W-1:0] frames_left_q, frames_left_d;
  logic                   frames_nz_q, frames_nz_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [DATA_BITS-1:0]   shl_q, shl_d;
  logic [DATA_BITS-1:0]   shr_q, shr_d;
  logic [DATA_BITS-1:0]   left_q, left_d;
  logic [DATA_BITS-1:0]   right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;

  logic tick;
  logic in_data;
  logic stop_now;

  assign tick     = (div_q == DivMax);
  assign in_data  = (bit_q >= DataFirst) && (bit_q <= DataLast);
  // A stop_i arriving on the frame-end fall itself must still end the run there.
  assign stop_now = stop_pend_q || stop_i || (frames_nz_q && (frames_left_q == '0));

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_d         = bit_q;
    sck_d         = sck_q;
    ws_d          = ws_q;
    frames_left_d = frames_left_q;
    frames_nz_d   = frames_nz_q;
    stop_pend_d   = stop_pend_q;
    shl_d         = shl_q;
    shr_d         = shr_q;
    left_d        = left_q;
    right_d       = right_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        sck_d = 1'b0;
        ws_d  = 1'b1;
        div_d = '0;
        bit_d = BitMax;
        if (start_i) begin
          state_d       = StRun;
          frames_left_d = frames_i;
          frames_nz_d   = (frames_i != '0);
          stop_pend_d   = 1'b0;
        end
      end
      StRun: begin
        if (stop_i) stop_pend_d = 1'b1;
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick && !sck_q) begin
          // Rising edge: capture sd_i MSB-first into the slot selected by ws.
          sck_d = 1'b1;
          if (in_data) begin
            if (ws_q) begin
              shr_d = {shr_q[DATA_BITS-2:0], sd_i};
              if (bit_q == DataLast) begin
                left_d  = shl_q;
                right_d = {shr_q[DATA_BITS-2:0], sd_i};
                valid_d = 1'b1;
                if (frames_left_q != '0) frames_left_d = frames_left_q - 1'b1;
              end
            end else begin
              shl_d = {shl_q[DATA_BITS-2:0], sd_i};
            end
          end
        end else if (tick) begin
          sck_d = 1'b0;
          if (bit_q == BitMax) begin
            if (ws_q && stop_now) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              bit_d = '0;
              ws_d  = ~ws_q;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      div_q         <= '0;
      bit_q         <= BitMax;
      sck_q         <= 1'b0;
      ws_q          <= 1'b1;
      frames_left_q <= '0;
      frames_nz_q   <= 1'b0;
      stop_pend_q   <= 1'b0;
      shl_q         <= '0;
      shr_q         <= '0;
      left_q        <= '0;
      right_q       <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      sck_q         <= sck_d;
      ws_q          <= ws_d;
      frames_left_q <= frames_left_d;
      frames_nz_q   <= frames_nz_d;
      stop_pend_q   <= stop_pend_d;
      shl_q         <= shl_d;
      shr_q         <= shr_d;
      left_q        <= left_d;
      right_q       <= right_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
    end
  end

  assign sck_o          = sck_q;
  assign ws_o           = ws_q;
  assign left_o         = left_q;
  assign right_o        = right_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q == StRun);
  assign done_o         = done_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Bench for i2s_frame_sequencer: a microphone model serves queued stereo frames and a
// scoreboard compares every published sample and the frame/busy/done timing.
module tb_i2s_frame_sequencer;

  localparam int ClkDiv      = 4;
  localparam int SlotBits    = 32;
  localparam int DataBits    = 24;
  localparam int DataOffset  = 2;
  localparam int FrameCntW   = 16;
  localparam int FramePeriod = 4 * SlotBits * ClkDiv;
  localparam int LeadIn      = 2 * ClkDiv;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b1;
  logic                 start_i = 1'b0;
  logic                 stop_i = 1'b0;
  logic [FrameCntW-1:0] frames_i = '0;
  logic                 sd_i = 1'b0;
  logic                 sck_o;
  logic                 ws_o;
  logic [DataBits-1:0]  left_o;
  logic [DataBits-1:0]  right_o;
  logic                 sample_valid_o;
  logic                 busy_o;
  logic                 done_o;

  always #5 clk_i = ~clk_i;

  i2s_frame_sequencer #(
    .CLK_DIV     (ClkDiv),
    .SLOT_BITS   (SlotBits),
    .DATA_BITS   (DataBits),
    .DATA_OFFSET (DataOffset),
    .FRAME_CNT_W (FrameCntW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .frames_i       (frames_i),
    .sd_i           (sd_i),
    .sck_o          (sck_o),
    .ws_o           (ws_o),
    .left_o         (left_o),
    .right_o        (right_o),
    .sample_valid_o (sample_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  int rise_cnt = 0;
  int frame_rise_cnt = 0;
  logic [47:0] tx_q[$];
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Microphone model plus scoreboard; one sample per clock, #1 after the rising edge.
  task automatic monitor();
    logic prev_sck = 1'b0;
    logic prev_ws = 1'b1;
    logic prev_busy = 1'b0;
    logic in_frame = 1'b0;
    int idx = 0;
    int turn = 0;
    int prev_valid = -1;
    logic [DataBits-1:0] cur_l = '0;
    logic [DataBits-1:0] cur_r = '0;
    logic [47:0] fr;
    logic [47:0] e;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (!rst_ni) begin
        prev_sck = 1'b0;
        prev_ws = 1'b1;
        prev_busy = 1'b0;
        in_frame = 1'b0;
        turn = 0;
        prev_valid = -1;
        exp_q.delete();
        sd_i = 1'b0;
        continue;
      end
      if (busy_o && !prev_busy) prev_valid = -1;
      if (busy_o) busy_cyc++;
      if (prev_sck && !sck_o) begin
        if (ws_o != prev_ws) begin
          idx = 0;
          if (!ws_o) begin
            if (tx_q.size() != 0) fr = tx_q.pop_front();
            else fr = {24'($urandom), 24'($urandom)};
            cur_l = fr[47:24];
            cur_r = fr[23:0];
            exp_q.push_back(fr);
            in_frame = 1'b1;
          end
        end else begin
          idx++;
        end
        sd_i = 1'($urandom);
        turn = 2;
      end else if (turn > 0) begin
        turn--;
        if (turn == 0) begin
          if (idx >= DataOffset && idx < DataOffset + DataBits)
            sd_i = ws_o ? cur_r[DataBits-1-(idx-DataOffset)] : cur_l[DataBits-1-(idx-DataOffset)];
          else
            sd_i = 1'($urandom);
        end
      end
      if (!prev_sck && sck_o) begin
        rise_cnt++;
        if (in_frame) frame_rise_cnt++;
      end
      if (sample_valid_o) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("valid_unexpected", 48'(1), 48'(0));
        end else begin
          e = exp_q.pop_front();
          check("left_sample", 48'(left_o), 48'(e[47:24]));
          check("right_sample", 48'(right_o), 48'(e[23:0]));
        end
        if (prev_valid >= 0) check("valid_spacing", 48'(cyc - prev_valid), 48'(FramePeriod));
        prev_valid = cyc;
      end
      if (done_o) begin
        done_cnt++;
        check("done_busy_low", 48'(busy_o), 48'(0));
        check("done_after_busy", 48'(prev_busy), 48'(1));
        in_frame = 1'b0;
      end
      prev_sck = sck_o;
      prev_ws = ws_o;
      prev_busy = busy_o;
    end
  endtask

  task automatic start_run(input int f);
    @(negedge clk_i);
    start_i = 1'b1;
    frames_i = FrameCntW'(f);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_done"}, 48'(done_cnt - d0), 48'(1));
  endtask

  task automatic wait_valid(input int target, input int budget, input string tag);
    int n = 0;
    while (valid_cnt < target && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_valid_reached"}, 48'(valid_cnt >= target), 48'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sck"}, 48'(sck_o), 48'(0));
    check({tag, "_ws"}, 48'(ws_o), 48'(1));
    check({tag, "_left"}, 48'(left_o), 48'(0));
    check({tag, "_right"}, 48'(right_o), 48'(0));
    check({tag, "_valid"}, 48'(sample_valid_o), 48'(0));
    check({tag, "_busy"}, 48'(busy_o), 48'(0));
    check({tag, "_done"}, 48'(done_o), 48'(0));
  endtask

  initial begin
    int v0;
    int b0;
    int r0;
    int fr0;
    int d0;
    int f;
    fork
      monitor();
    join_none

    // Power-up reset, asserted before any clock edge.
    #1 rst_ni = 1'b0;
    #2;
    check_reset_outputs("por");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // T1: reset mid-cycle while SCK high in the left slot.
    start_run(0);
    repeat (206) @(negedge clk_i);
    check("t1_pre_sck", 48'(sck_o), 48'(1));
    check("t1_pre_ws", 48'(ws_o), 48'(0));
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("t1");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    r0 = rise_cnt;
    repeat (10) @(negedge clk_i);
    check("t1_idle_rises", 48'(rise_cnt - r0), 48'(0));
    check("t1_idle_ws", 48'(ws_o), 48'(1));

    // T2: single frame with fixed data.
    tx_q.push_back({24'hA5F00F, 24'h5A0FF0});
    v0 = valid_cnt; b0 = busy_cyc; fr0 = frame_rise_cnt;
    start_run(1);
    wait_done(2000, "t2");
    check("t2_valids", 48'(valid_cnt - v0), 48'(1));
    check("t2_rises", 48'(frame_rise_cnt - fr0), 48'(2 * SlotBits));
    check("t2_busy_cycles", 48'(busy_cyc - b0), 48'(FramePeriod + LeadIn));
    check("t2_left", 48'(left_o), 48'(24'hA5F00F));
    check("t2_right", 48'(right_o), 48'(24'h5A0FF0));
    check("t2_ws_end", 48'(ws_o), 48'(1));
    check("t2_sck_end", 48'(sck_o), 48'(0));

    // T3: three counted frames.
    tx_q.push_back({24'd1, 24'd2});
    tx_q.push_back({24'd3, 24'd4});
    tx_q.push_back({24'd5, 24'd6});
    v0 = valid_cnt; b0 = busy_cyc;
    start_run(3);
    wait_done(4000, "t3");
    check("t3_valids", 48'(valid_cnt - v0), 48'(3));
    check("t3_busy_cycles", 48'(busy_cyc - b0), 48'(3 * FramePeriod + LeadIn));
    check("t3_left", 48'(left_o), 48'(5));
    check("t3_right", 48'(right_o), 48'(6));
    check("t3_ws_end", 48'(ws_o), 48'(1));

    // T4: continuous run stopped mid-left slot of frame 3; stop in IDLE is inert.
    repeat (3) tx_q.push_back({24'($urandom), 24'($urandom)});
    v0 = valid_cnt; b0 = busy_cyc;
    start_run(0);
    wait_valid(v0 + 2, 2000, "t4");
    repeat (180) @(negedge clk_i);
    check("t4_mid_left_ws", 48'(ws_o), 48'(0));
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    wait_done(1000, "t4");
    check("t4_valids", 48'(valid_cnt - v0), 48'(3));
    check("t4_busy_cycles", 48'(busy_cyc - b0), 48'(3 * FramePeriod + LeadIn));
    check("t4_no_extra_frame", 48'(exp_q.size()), 48'(0));
    d0 = done_cnt; b0 = busy_cyc;
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("t4_idle_stop_busy", 48'(busy_cyc - b0), 48'(0));
    check("t4_idle_stop_done", 48'(done_cnt - d0), 48'(0));

    // T5: start re-pulsed while busy, stop coincident with the frame-2 end fall.
    repeat (2) tx_q.push_back({24'($urandom), 24'($urandom)});
    v0 = valid_cnt; b0 = busy_cyc; d0 = done_cnt;
    start_run(0);
    repeat (600) @(negedge clk_i);
    start_i = 1'b1;
    frames_i = FrameCntW'(1);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (430) @(negedge clk_i);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    check("t5_busy_fell", 48'(busy_o), 48'(0));
    check("t5_done_now", 48'(done_o), 48'(1));
    repeat (4) @(negedge clk_i);
    check("t5_done_count", 48'(done_cnt - d0), 48'(1));
    check("t5_valids", 48'(valid_cnt - v0), 48'(2));
    check("t5_busy_cycles", 48'(busy_cyc - b0), 48'(2 * FramePeriod + LeadIn));
    check("t5_no_extra_frame", 48'(exp_q.size()), 48'(0));

    // T6: reset during right-slot bit 10, then a clean single-frame restart.
    tx_q.push_back({24'($urandom), 24'($urandom)});
    tx_q.push_back({24'h800001, 24'h7FFFFF});
    v0 = valid_cnt; d0 = done_cnt;
    start_run(1);
    repeat (346) @(negedge clk_i);
    check("t6_pre_ws", 48'(ws_o), 48'(1));
    #1 rst_ni = 1'b0;
    #1;
    check_reset_outputs("t6");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    check("t6_no_stale_done", 48'(done_cnt - d0), 48'(0));
    start_run(1);
    wait_done(2000, "t6");
    check("t6_valids", 48'(valid_cnt - v0), 48'(1));
    check("t6_left", 48'(left_o), 48'(24'h800001));
    check("t6_right", 48'(right_o), 48'(24'h7FFFFF));

    // Randomized frame counts and data.
    for (int i = 0; i < 3; i++) begin
      f = int'($urandom_range(1, 3));
      repeat (f) tx_q.push_back({24'($urandom), 24'($urandom)});
      v0 = valid_cnt; b0 = busy_cyc;
      start_run(f);
      wait_done(f * FramePeriod + 200, "rnd");
      check("rnd_valids", 48'(valid_cnt - v0), 48'(f));
      check("rnd_busy_cycles", 48'(busy_cyc - b0), 48'(f * FramePeriod + LeadIn));
      check("rnd_ws_end", 48'(ws_o), 48'(1));
      check("rnd_no_extra_frame", 48'(exp_q.size()), 48'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
